dec_stage: RTL

DEC_STAGE -- requirements
Module: dec_stage

---
 rtl/dec_stage.sv | 79 +++++++
 1 files changed

// File: rtl/dec_stage.sv
// Decode stage: 32x32 register file, immediate extension and registered operand capture.
// Define DEC_STAGE_BYPASS_EN to forward same-edge writeback data into captured operands.
module dec_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        Instr_valid,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        RF_WrEn,
    input  logic [4:0]  RF_WrAddr,
    input  logic        RF_WrData_sel,
    input  logic [31:0] ALU_out,
    input  logic [31:0] MEM_out,
    input  logic        RF_B_sel,
    input  logic [1:0]  ImmExt,
    output logic [31:0] RF_A,
    output logic [31:0] RF_B,
    output logic [31:0] Immed,
    output logic [5:0]  Opcode,
    output logic [4:0]  Rd,
    output logic        Dec_valid
);
    logic [31:0] regs [32];
    logic [31:0] wr_data, rd_a, rd_b, imm_ext;
    logic [4:0]  addr_a, addr_b;
    logic [15:0] imm16;

    assign wr_data = RF_WrData_sel ? MEM_out : ALU_out;
    assign addr_a  = Instr[25:21];
    assign addr_b  = RF_B_sel ? Instr[20:16] : Instr[15:11];
    assign imm16   = Instr[15:0];

    // r0 is never written, but reads are forced to zero so the bypass path cannot leak into it.
    always_comb begin
        rd_a = (addr_a == 5'd0) ? 32'd0 : regs[addr_a];
        rd_b = (addr_b == 5'd0) ? 32'd0 : regs[addr_b];
`ifdef DEC_STAGE_BYPASS_EN
        if (RF_WrEn && RF_WrAddr != 5'd0 && RF_WrAddr == addr_a) rd_a = wr_data;
        if (RF_WrEn && RF_WrAddr != 5'd0 && RF_WrAddr == addr_b) rd_b = wr_data;
`endif
    end

    always_comb begin
        case (ImmExt)
            2'b00:   imm_ext = {16'h0000, imm16};
            2'b01:   imm_ext = {{16{imm16[15]}}, imm16};
            2'b10:   imm_ext = {{14{imm16[15]}}, imm16, 2'b00};
            default: imm_ext = {imm16, 16'h0000};
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (RF_WrEn && RF_WrAddr != 5'd0) begin
            regs[RF_WrAddr] <= wr_data;
        end
    end

    // Flush loads the operands like a normal capture but marks them dead, overriding Stall.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            RF_A      <= 32'd0;
            RF_B      <= 32'd0;
            Immed     <= 32'd0;
            Opcode    <= 6'd0;
            Rd        <= 5'd0;
            Dec_valid <= 1'b0;
        end else if (Flush || !Stall) begin
            RF_A      <= rd_a;
            RF_B      <= rd_b;
            Immed     <= imm_ext;
            Opcode    <= Instr[31:26];
            Rd        <= Instr[20:16];
            Dec_valid <= Instr_valid && !Flush;
        end
    end
endmodule
